// File: rtl/bcd_7seg_scan.sv
// bcd_7seg_scan: time-multiplexed 3-digit 7-segment driver fed by a BCD converter.
// Captured values are double-buffered and moved to the display only at a scan-frame
// boundary, so a digit never shows a half-updated value.
// Optional build macro BCD_LEADING_ZERO_BLANK_EN: blank the leading zeros of the
// hundreds and tens digits (the ones digit is always shown).
//
// Scan state table:
//   state       | meaning
//   DIG_ONES    | units digit enabled (an[0])
//   DIG_TENS    | tens digit enabled (an[1])
//   DIG_HUND    | hundreds digit enabled (an[2]); leaving it closes a frame
//   DIG_ILLEGAL | unreachable; all digits off, next advance returns to DIG_ONES
module bcd_7seg_scan #(
  parameter int CLK_DIV        = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [1:0] hundreds,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame
);

  localparam logic [15:0] PRE_LAST = 16'(CLK_DIV - 1);
  localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0]  AN_OFF   = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {
    DIG_ONES    = 2'd0,
    DIG_TENS    = 2'd1,
    DIG_HUND    = 2'd2,
    DIG_ILLEGAL = 2'd3
  } digit_t;

  // Segment patterns are active-high {g,f,e,d,c,b,a}; non-decimal codes show a dash.
  function automatic logic [6:0] decode_digit(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b1000000;
    endcase
    return p;
  endfunction

  digit_t      state_q, state_d;
  logic [15:0] pre_q, pre_d;
  logic        adv;
  logic        boundary;

  // Buffers are packed {hundreds[1:0], tens[3:0], ones[3:0]}.
  logic [9:0]  pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [9:0]  disp_q, disp_d;
  logic        frame_d;

  logic [3:0]  digit_val;
  logic        blank;
  logic [6:0]  seg_on;
  logic [2:0]  an_on;
  logic [6:0]  seg_d;
  logic [2:0]  an_d;

  logic [6:0]  seg_q;
  logic [2:0]  an_q;
  logic        frame_q;

  // Dwell prescaler: wraps after CLK_DIV cycles and requests a digit advance.
  always_comb begin
    adv   = (pre_q == PRE_LAST);
    pre_d = adv ? 16'd0 : pre_q + 16'd1;
  end

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIG_ONES;
      pre_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
    end
  end

  // Next scan state: ones -> tens -> hundreds -> ones on each advance.
  always_comb begin
    state_d = state_q;
    if (adv) begin
      case (state_q)
        DIG_ONES: state_d = DIG_TENS;
        DIG_TENS: state_d = DIG_HUND;
        default:  state_d = DIG_ONES;
      endcase
    end
  end

  // Frame boundary handling: pending moves to display only when leaving hundreds.
  always_comb begin
    boundary     = adv && (state_q == DIG_HUND);
    frame_d      = boundary && pend_valid_q;
    disp_d       = frame_d ? pend_q : disp_q;
    pend_d       = load ? {hundreds, tens, ones} : pend_q;
    pend_valid_d = pend_valid_q;
    if (frame_d) begin
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_valid_d = 1'b1;
    end
  end

  // Scan outputs computed from the post-edge state so segments and enables move together.
  always_comb begin
    digit_val = disp_d[3:0];
    blank     = 1'b0;
    an_on     = 3'b000;
    case (state_d)
      DIG_ONES: begin
        digit_val = disp_d[3:0];
        an_on     = 3'b001;
      end
      DIG_TENS: begin
        digit_val = disp_d[7:4];
        an_on     = 3'b010;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        blank     = (disp_d[9:4] == 6'd0);
`endif
      end
      DIG_HUND: begin
        digit_val = {2'b00, disp_d[9:8]};
        an_on     = 3'b100;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        blank     = (disp_d[9:8] == 2'd0);
`endif
      end
      default: begin
        digit_val = 4'd0;
        an_on     = 3'b000;
        blank     = 1'b1;
      end
    endcase
    seg_on = blank ? 7'b0000000 : decode_digit(digit_val);
    seg_d  = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
    an_d   = AN_ACTIVE_LOW ? ~an_on : an_on;
  end

  // Data buffers, frame pulse and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q       <= 10'd0;
      pend_valid_q <= 1'b0;
      disp_q       <= 10'd0;
      frame_q      <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      disp_q       <= disp_d;
      frame_q      <= frame_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Scoreboard bench for bcd_7seg_scan (CLK_DIV=4, active-low outputs).
// The reference model works from elapsed clock edges since reset release: the
// digit shown is (edges / CLK_DIV) mod 3 and frames close every 3*CLK_DIV edges.
module tb_bcd_7seg_scan;

  localparam int CLK_DIV   = 4;
  localparam int FRAME_LEN = 3 * CLK_DIV;

  typedef struct {
    int h;
    int t;
    int o;
  } bcd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] ones = 4'd0;
  logic [3:0] tens = 4'd0;
  logic [1:0] hundreds = 2'd0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame;

  bcd_7seg_scan #(
    .CLK_DIV(CLK_DIV),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .ones(ones),
    .tens(tens),
    .hundreds(hundreds),
    .seg(seg),
    .an(an),
    .frame(frame)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  int   pushes = 0;
  int   frames_seen = 0;
  bit   m_pv = 1'b0;
  bcd_t m_pend = '{0, 0, 0};
  bcd_t cur = '{0, 0, 0};
  bcd_t exp_q[$];
  logic [6:0] seg_tab [16];

  initial begin
    seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
                7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] exp_pattern(input bcd_t v, input int idx);
    int d;
    logic [6:0] p;
    d = (idx == 0) ? v.o : (idx == 1) ? v.t : v.h;
    p = seg_tab[d];
`ifdef BCD_LEADING_ZERO_BLANK_EN
    if (idx == 2 && v.h == 0) p = 7'b0000000;
    if (idx == 1 && v.h == 0 && v.t == 0) p = 7'b0000000;
`endif
    return p;
  endfunction

  // Reference model: tracks captures and queues each value expected to reach the display.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0;
      m_pv = 1'b0;
      m_pend = '{0, 0, 0};
      exp_q.delete();
    end else begin
      k++;
      if ((k % FRAME_LEN) == 0 && m_pv) begin
        exp_q.push_back(m_pend);
        pushes++;
        m_pv = 1'b0;
      end
      if (load) begin
        m_pend = '{int'(hundreds), int'(tens), int'(ones)};
        m_pv = 1'b1;
      end
    end
  end

  // Monitor: pops on each expected frame and checks every scanned digit.
  always @(negedge clk) begin
    int idx;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    if (frame === 1'b1) frames_seen++;
    if (rst || k == 0) begin
      cur = '{0, 0, 0};
      check("off_seg", {25'd0, seg}, 32'h7F);
      check("off_an", {29'd0, an}, 32'h7);
      check("off_frame", {31'd0, frame}, 32'd0);
    end else begin
      idx = (k / CLK_DIV) % 3;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        check("frame_missing", {31'd0, frame}, 32'd1);
      end else begin
        check("frame_spurious", {31'd0, frame}, 32'd0);
      end
      exp_an  = ~(3'(1) << idx);
      exp_seg = ~exp_pattern(cur, idx);
      check("scan_an", {29'd0, an}, {29'd0, exp_an});
      check("scan_seg", {25'd0, seg}, {25'd0, exp_seg});
    end
  end

  // Drive one load cycle; caller is positioned at a falling edge.
  task automatic do_load(input int h, input int t, input int o);
    logic [31:0] hv, tv, ov;
    hv = h; tv = t; ov = o;
    #1;
    hundreds = hv[1:0];
    tens     = tv[3:0];
    ones     = ov[3:0];
    load     = 1'b1;
    @(negedge clk);
    #1 load = 1'b0;
  endtask

  // Advance to the falling edge after the edge whose frame phase is p.
  task automatic wait_phase(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((k % FRAME_LEN) != p && n < 2 * FRAME_LEN);
    check("phase_wait", k % FRAME_LEN, p);
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FRAME_LEN) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) @(negedge clk);

    // asynchronous reset in the middle of a scan
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_async_seg", {25'd0, seg}, 32'h7F);
    check("rst_async_an", {29'd0, an}, 32'h7);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    wait_frames(1);

    // 255
    wait_phase(1);
    do_load(2, 5, 5);
    wait_frames(2);

    // last load in a frame wins
    wait_phase(1);
    do_load(1, 2, 3);
    repeat (3) @(negedge clk);
    do_load(0, 4, 5);
    wait_frames(2);

    // load coincident with the frame boundary
    wait_phase(5);
    do_load(1, 0, 0);
    wait_phase(FRAME_LEN - 1);
    do_load(0, 0, 9);
    wait_frames(3);

    // non-decimal ones digit
    do_load(1, 7, 12);
    wait_frames(2);

    // leading zeros
    do_load(0, 0, 7);
    wait_frames(2);
    do_load(0, 0, 0);
    wait_frames(2);

    // randomized captures at random spacing
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2 * FRAME_LEN)) @(negedge clk);
      do_load($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
    end
    wait_frames(2);

    // reset discards a pending value not yet displayed
    wait_phase(2);
    do_load(2, 1, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    wait_frames(3);

    check("queue_drain", exp_q.size(), 0);
    check("frame_count", frames_seen, pushes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_7seg_scan.md
Name: bcd_7seg_scan

Overview:
- Downstream consumer of the binary-to-BCD converter: takes the 3-digit BCD result (ones, tens, 2-bit hundreds) and drives a time-multiplexed common-anode/cathode 7-segment display.
- Double-buffers the value so that display updates only at a scan-frame boundary, which prevents digit tearing.
- Prescales the system clock to the per-digit dwell time and scans ones -> tens -> hundreds.

Parameters:
- CLK_DIV, 1000: clock cycles each digit is enabled; legal range 2..65535.
- SEG_ACTIVE_LOW, 1: 1 = seg outputs inverted (segment on = 0).
- AN_ACTIVE_LOW, 1: 1 = an outputs inverted (digit enabled = 0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- load  in  1  capture strobe; samples ones/tens/hundreds on the clk edge where it is high.
- ones  in  4  BCD units digit.
- tens  in  4  BCD tens digit.
- hundreds  in  2  BCD hundreds digit (0..2).
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- an  out  3  digit enables, an[0]=ones, an[1]=tens, an[2]=hundreds, polarity per AN_ACTIVE_LOW.
- frame  out  1  one-cycle pulse when a new value is transferred to the display buffer.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; it acts immediately, with no clock required.
- Reset values:
  - prescaler = 0, digit index = 0.
  - pending and display buffers = 0, pending_valid = 0, frame = 0.
  - seg = all segments off and an = all digits disabled, each at its configured polarity.
- Capture:
  - load=1 on an edge writes {hundreds,tens,ones} into the pending buffer and sets pending_valid.
  - Back-to-back loads overwrite; the last one wins.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - A digit advance happens on the edge where prescaler == CLK_DIV-1.
- Digit index:
  - Sequence is 0 -> 1 -> 2 -> 0.
  - Index 3 is unreachable; if it is ever entered, the next advance goes to 0.
- Frame boundary: the digit advance from index 2 to 0.
  - On that edge, if pending_valid=1: display <= pending, pending_valid <= 0, and frame = 1 for exactly that cycle.
  - If load is also high on that same edge: display takes the pre-edge pending contents, pending takes the new inputs, and pending_valid stays 1.
- Outputs:
  - seg and an are registered and update on the same edge as the index change. The first lit digit (ones) appears on the first edge after reset release.
  - Exactly one an bit is active at a time while out of reset.
- Decoding (internal active-high, shown as {g..a}):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Any value 10..15 shows a dash: 1000000.
  - hundreds is zero-extended to 4 bits before decoding.
- Reset mid-frame: all state is cleared, including a pending load that has not yet been displayed; scanning restarts at ones.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - The hundreds digit shows blank (seg all off, an still active) when it is 0.
  - The tens digit shows blank when both hundreds and tens are 0.
  - The ones digit is never blanked, so 0 displays as a single "0".
  - Blanking is evaluated on the display buffer, not on the pending buffer.
- Undefined: all three digits are always decoded; 7 displays as "007".

Test Plan:
- Reset check, CLK_DIV=4: assert rst mid-scan -> seg=7'h7F and an=3'b111 immediately (active-low). After release: an=3'b110 with the ones pattern, and the digit advances every 4 cycles.
- Load 2/5/5 (255), then wait one full frame -> frame pulses once. Then an=110 gives seg=~7'b1101101, an=101 gives ~7'b1101101, an=011 gives ~7'b1011011.
- load pulsed with 1/2/3, then with 0/4/5 within one frame -> only 045 is shown after the boundary; frame pulses once.
- load asserted exactly on the 2->0 boundary edge with 0/0/9 while pending holds 1/0/0 -> 100 is displayed this frame, and 009 at the next boundary with a second frame pulse.
- ones=4'hC loaded -> the ones digit shows 7'b1000000 (dash) and the other digits are unaffected.
- Built with BCD_LEADING_ZERO_BLANK_EN, load 0/0/7 -> hundreds and tens show seg=7'h7F while their an is active, and ones shows ~7'b0000111. Built without the macro -> "007".
